// File: rtl/uart_pkg.sv
// Shared types and register map constants for the memory-mapped UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

  // Register offsets, selected by addr[3:2]
  localparam logic [1:0] OffData   = 2'd0;
  localparam logic [1:0] OffStatus = 2'd1;
  localparam logic [1:0] OffCtrl   = 2'd2;

  localparam int unsigned StatFull  = 0;
  localparam int unsigned StatEmpty = 1;
  localparam int unsigned StatBusy  = 2;
  localparam int unsigned StatOvf   = 3;
  localparam int unsigned StatCnt   = 8;

  localparam int unsigned CtrlEn    = 0;
  localparam int unsigned CtrlIrqEn = 1;

endpackage

// File: rtl/uart_tx_mmio_if.sv
// Data-memory-side bus between the core and the UART register window.
interface uart_tx_mmio_if;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        hit;

  modport master (output we, addr, wdata, input rdata, hit);
  modport slave  (input we, addr, wdata, output rdata, hit);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data; push when full and
// pop when empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [PW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [PW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PW'(1);
      if (do_pop)  rptr_q <= rptr_q + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO, baud counter and FSM.
// Optional transmit-complete interrupt enabled by defining UART_TX_IRQ_EN.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int unsigned DIVISOR    = 434,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_mmio_if.slave  bus,
`ifdef UART_TX_IRQ_EN
  output logic           irq,
`endif
  output logic           txd
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BW = $clog2(DIVISOR);
  localparam logic [BW-1:0] BaudMax = BW'(DIVISOR - 1);

  tx_state_e     state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          txd_q;
  logic          enable_q, ovf_q;

  logic          wr, push, pop, full, empty, baud_done;
  logic [1:0]    off;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] count;
  logic          unused_bits;

  assign bus.hit     = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign off         = bus.addr[3:2];
  assign wr          = bus.we && bus.hit;
  assign push        = wr && (off == OffData);
  assign baud_done   = (baud_q == '0);
  assign unused_bits = ^{bus.addr[1:0], bus.wdata[31:8]};

  // Pop from idle, or on the final stop-bit cycle so frames run back to back
  assign pop = enable_q && !empty &&
               ((state_q == StIdle) || ((state_q == StStop) && baud_done));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (bus.wdata[7:0]),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

`ifdef UART_TX_IRQ_EN
  logic irq_en_q, irq_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr && (off == OffCtrl)) irq_en_q <= bus.wdata[CtrlIrqEn];
      irq_q <= irq_en_q && empty && (state_q == StIdle);
    end
  end

  assign irq = irq_q;
`endif

  always_comb begin
    bus.rdata = '0;
    if (bus.hit) begin
      unique case (off)
        OffStatus: begin
          bus.rdata[StatFull]       = full;
          bus.rdata[StatEmpty]      = empty;
          bus.rdata[StatBusy]       = (state_q != StIdle);
          bus.rdata[StatOvf]        = ovf_q;
          bus.rdata[StatCnt +: CW]  = count;
        end
        OffCtrl: begin
          bus.rdata[CtrlEn]    = enable_q;
`ifdef UART_TX_IRQ_EN
          bus.rdata[CtrlIrqEn] = irq_en_q;
`endif
        end
        default: bus.rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_q <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      if (wr && (off == OffCtrl)) enable_q <= bus.wdata[CtrlEn];
      if (wr && (off == OffStatus)) ovf_q <= 1'b0;
      else if (push && full)        ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            shift_q <= fifo_rdata;
            baud_q  <= BaudMax;
            state_q <= StStart;
            txd_q   <= 1'b0;
          end
        end
        StStart: begin
          if (baud_done) begin
            baud_q  <= BaudMax;
            bit_q   <= '0;
            state_q <= StData;
            txd_q   <= shift_q[0];
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
        StData: begin
          if (baud_done) begin
            baud_q <= BaudMax;
            if (bit_q == 3'd7) begin
              state_q <= StStop;
              txd_q   <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= shift_q >> 1;
              txd_q   <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
        StStop: begin
          if (baud_done) begin
            if (pop) begin
              shift_q <= fifo_rdata;
              baud_q  <= BaudMax;
              state_q <= StStart;
              txd_q   <= 1'b0;
            end else begin
              state_q <= StIdle;
              txd_q   <= 1'b1;
            end
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign txd = txd_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Scoreboard bench: stimulus queues expected bytes, an independent serial monitor
// decodes txd frames and compares them in order.
module tb_uart_tx_mmio;

  localparam int unsigned D     = 4;
  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam logic [31:0] A_DATA = BASE + 32'h0;
  localparam logic [31:0] A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_CTRL = BASE + 32'h8;
  localparam logic [31:0] A_RSVD = BASE + 32'hC;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic txd;
`ifdef UART_TX_IRQ_EN
  logic irq;
`endif

  uart_tx_mmio_if bus ();

  uart_tx_mmio #(
    .BASE_ADDR  (BASE),
    .DIVISOR    (D),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
`ifdef UART_TX_IRQ_EN
    .irq   (irq),
`endif
    .txd   (txd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int starts[$];
  int wr_cyc;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.we = 1'b1;
    bus.addr = a;
    bus.wdata = d;
    @(negedge clk);
    bus.we = 1'b0;
    wr_cyc = cyc;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.we = 1'b0;
    bus.addr = a;
    #1 d = bus.rdata;
  endtask

  task automatic send(input logic [7:0] b);
    wr(A_DATA, {24'h0, b});
    exp_q.push_back(b);
  endtask

  task automatic wait_idle();
    logic [31:0] st;
    bit done;
    done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      rd(A_STAT, st);
      if (st[1] && !st[2]) done = 1;
    end
    chk("idle_reached", {31'h0, done}, 32'h1);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  // Serial receiver: frame begins at the first low sample; every bit must hold for D cycles
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && txd === 1'b0) begin
        logic [9:0] bits;
        bit aborted, unstable;
        logic [7:0] e;
        starts.push_back(cyc);
        aborted = 0;
        unstable = 0;
        bits = '0;
        for (int i = 0; i < 10; i++) begin
          for (int j = 0; j < int'(D); j++) begin
            if (i != 0 || j != 0) @(negedge clk);
            if (reset) aborted = 1;
            if (j == 0) bits[i] = txd;
            else if (txd !== bits[i]) unstable = 1;
          end
        end
        if (!aborted) begin
          chk("frame_format", {29'h0, unstable, bits[0], bits[9]}, 32'h1);
          chk("frame_queued", {31'h0, exp_q.size() > 0}, 32'h1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("frame_byte", {24'h0, bits[8:1]}, {24'h0, e});
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] d;
    int n, cnt, s;
    bus.we = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state and decode
    rd(A_STAT, d);
    chk("reset_status", d, 32'h2);
    chk("reset_txd", {31'h0, txd}, 32'h1);
    chk("hit_in_window", {31'h0, bus.hit}, 32'h1);
    rd(A_CTRL, d);
    chk("reset_ctrl", d, 32'h1);
    rd(32'h0000_0004, d);
    chk("miss_rdata", d, 32'h0);
    chk("miss_hit", {31'h0, bus.hit}, 32'h0);
`ifdef UART_TX_IRQ_EN
    chk("reset_irq", {31'h0, irq}, 32'h0);
`endif

    // Single frame with latency check
    send(8'h55);
    s = wr_cyc;
    wait_idle();
    chk("start_latency", starts[$], s + 1);
    rd(A_STAT, d);
    chk("status_after_frame", d, 32'h2);

    // Back-to-back frames
    send(8'hA5);
    send(8'h3C);
    wait_idle();
    chk("no_gap", starts[$] - starts[$-1], 10 * D);

    // Reserved/DATA reads and ignored write
    wr(A_RSVD, 32'hFFFF_FFFF);
    rd(A_RSVD, d);
    chk("reserved_reads_0", d, 32'h0);
    rd(A_DATA, d);
    chk("data_reads_0", d, 32'h0);

    // Overflow with transmitter disabled
    wr(A_CTRL, 32'h0);
    cnt = 0;
    for (int i = 0; i < 9; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      wr(A_DATA, {24'h0, b});
      if (cnt < int'(DEPTH)) begin
        exp_q.push_back(b);
        cnt++;
      end
    end
    rd(A_STAT, d);
    chk("overflow_status", d, (32'(cnt) << 8) | 32'h9);
    wr(A_STAT, 32'h0);
    rd(A_STAT, d);
    chk("overflow_cleared", d, (32'(cnt) << 8) | 32'h1);
    wr(A_CTRL, 32'h1);
    wait_idle();

    // Randomised bursts that never exceed the FIFO depth
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        send(8'($urandom));
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle();
      rd(A_STAT, d);
      chk("random_idle_status", d, 32'h2);
    end

    // Reset in the middle of data bit 3 (0x96 -> bit3 = 0)
    send(8'h96);
    repeat (18) @(negedge clk);
    chk("bit3_before_reset", {31'h0, txd}, 32'h0);
    reset = 1'b1;
    #1 chk("txd_on_reset", {31'h0, txd}, 32'h1);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    rd(A_STAT, d);
    chk("status_after_reset", d, 32'h2);
    n = starts.size();
    repeat (60) @(negedge clk);
    chk("no_residual_frame", starts.size(), n);

    // CTRL irq_en bit
    wr(A_CTRL, 32'h3);
    rd(A_CTRL, d);
`ifdef UART_TX_IRQ_EN
    chk("ctrl_irq_en", d, 32'h3);
    repeat (2) @(negedge clk);
    chk("irq_idle_high", {31'h0, irq}, 32'h1);
    send(8'h5A);
    repeat (2) @(negedge clk);
    chk("irq_low_busy", {31'h0, irq}, 32'h0);
    wait_idle();
    @(negedge clk);
    chk("irq_done_high", {31'h0, irq}, 32'h1);
`else
    chk("ctrl_no_irq_en", d, 32'h1);
    send(8'h5A);
    wait_idle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1);
  end

endmodule
